// File: rtl/obi_wb_pipe_bridge_if.sv
// OBI slave / Wishbone classic master signal bundle for obi_wb_pipe_bridge.
// The master modport is the bridge's view (it masters the Wishbone side);
// the slave modport is the view of the core and peripheral around it.
interface obi_wb_pipe_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   // OBI side
   logic                  obi_req_i;
   logic                  obi_gnt_o;
   logic [ADDR_WIDTH-1:0] obi_addr_i;
   logic                  obi_we_i;
   logic [BE_WIDTH-1:0]   obi_be_i;
   logic [DATA_WIDTH-1:0] obi_wdata_i;
   logic                  obi_rvalid_o;
   logic [DATA_WIDTH-1:0] obi_rdata_o;
   logic                  obi_err_o;

   // Wishbone side
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [BE_WIDTH-1:0]   wb_sel_o;
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic [DATA_WIDTH-1:0] wb_dat_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;

   modport master (
      input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
   );

   modport slave (
      output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
   );
endinterface

// File: rtl/obi_wb_pipe_bridge.sv
// OBI (slave) to Wishbone classic (master) bridge, one transaction outstanding.
// IDLE/RESP grant new requests; BUS runs the WB cycle until ack, err or timeout.
module obi_wb_pipe_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          WB_WORD_ADDR   = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   obi_wb_pipe_bridge_if.master  bus
);
   localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8;
   localparam int unsigned ADDR_SHIFT   = $clog2(BE_WIDTH);
   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [BE_WIDTH-1:0]   r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic [15:0]           r_tcnt;

   logic                  w_gnt;
   logic                  w_accept;
   logic                  w_timeout;
   logic                  w_bus_done;
   logic [ADDR_WIDTH-1:0] w_adr;

   // Grant, accept and BUS exit decode
   always_comb begin
      w_gnt      = (r_state != StBus);
      w_accept   = bus.obi_req_i && w_gnt;
      w_timeout  = TIMEOUT_EN && (r_tcnt == TIMEOUT_LAST);
      w_bus_done = (r_state == StBus) && (bus.wb_err_i || bus.wb_ack_i || w_timeout);
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_d = StBus;
         StBus:   if (w_bus_done) w_state_d = StResp;
         StResp:  w_state_d = w_accept ? StBus : StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // State register; reset drops an in-flight cycle without a response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Request latch, timeout counter and response capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_tcnt  <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= bus.obi_addr_i;
            r_we    <= bus.obi_we_i;
            r_be    <= bus.obi_be_i;
            r_wdata <= bus.obi_wdata_i;
            r_tcnt  <= '0;
         end else if (r_state == StBus) begin
            r_tcnt <= r_tcnt + 16'd1;
         end
         if (w_bus_done) begin
            // err wins over ack; timeout only counts when neither arrived
            r_err   <= bus.wb_err_i || !bus.wb_ack_i;
            r_rdata <= (bus.wb_ack_i && !bus.wb_err_i && !r_we) ? bus.wb_dat_i : '0;
         end
      end
   end

   // Word addressing drops the byte-lane bits and zero-fills the top
   if (WB_WORD_ADDR) begin : g_word_adr
      assign w_adr = r_addr >> ADDR_SHIFT;
   end else begin : g_byte_adr
      assign w_adr = r_addr;
   end

   // Output mapping
   always_comb begin
      bus.obi_gnt_o    = w_gnt;
      bus.obi_rvalid_o = (r_state == StResp);
      bus.obi_rdata_o  = r_rdata;
      bus.obi_err_o    = r_err;
      bus.wb_cyc_o     = (r_state == StBus);
      bus.wb_stb_o     = (r_state == StBus);
      bus.wb_we_o      = r_we;
      bus.wb_sel_o     = r_be;
      bus.wb_adr_o     = w_adr;
      bus.wb_dat_o     = r_wdata;
   end
endmodule

// File: tb/tb_obi_wb_pipe_bridge.sv
// Bench for obi_wb_pipe_bridge: a 32-bit byte-addressed and a 64-bit word-addressed
// bridge run side by side on the same stimulus, checked against a transaction model.
module tb_obi_wb_pipe_bridge;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req, we, ack, err;
   logic [31:0] addr;
   logic [7:0]  be;
   logic [63:0] wdata, dat_i;

   int n_vec = 0;
   int n_mis = 0;

   obi_wb_pipe_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if32 ();
   obi_wb_pipe_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) if64 ();

   assign if32.obi_req_i   = req;
   assign if32.obi_addr_i  = addr;
   assign if32.obi_we_i    = we;
   assign if32.obi_be_i    = be[3:0];
   assign if32.obi_wdata_i = wdata[31:0];
   assign if32.wb_dat_i    = dat_i[31:0];
   assign if32.wb_ack_i    = ack;
   assign if32.wb_err_i    = err;

   assign if64.obi_req_i   = req;
   assign if64.obi_addr_i  = addr;
   assign if64.obi_we_i    = we;
   assign if64.obi_be_i    = be;
   assign if64.obi_wdata_i = wdata;
   assign if64.wb_dat_i    = dat_i;
   assign if64.wb_ack_i    = ack;
   assign if64.wb_err_i    = err;

   obi_wb_pipe_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_WORD_ADDR(1'b0), .TIMEOUT_CYCLES(TO)
   ) u_dut32 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if32)
   );

   obi_wb_pipe_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .WB_WORD_ADDR(1'b1), .TIMEOUT_CYCLES(TO)
   ) u_dut64 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if64)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response model: kind 0 = ack, 1 = err, 2 = ack+err, 3 = no response (timeout)
   function automatic void predict(input logic w, input int kind, input logic [63:0] d,
                                   output logic e, output logic [63:0] rd);
      e  = (kind != 0);
      rd = (kind == 0 && !w) ? d : 64'd0;
   endfunction

   // Expected view of both bridges during a BUS cycle
   task automatic chk_bus(input string tag, input logic [31:0] a, input logic w,
                          input logic [7:0] b, input logic [63:0] wd);
      chk({tag, " ctl32"}, 128'({if32.wb_cyc_o, if32.wb_stb_o, if32.wb_we_o,
                                 if32.obi_gnt_o, if32.obi_rvalid_o}), 128'({2'b11, w, 2'b00}));
      chk({tag, " bus32"}, 128'({if32.wb_sel_o, if32.wb_adr_o, if32.wb_dat_o}),
          128'({b[3:0], a, wd[31:0]}));
      chk({tag, " ctl64"}, 128'({if64.wb_cyc_o, if64.wb_stb_o, if64.wb_we_o,
                                 if64.obi_gnt_o, if64.obi_rvalid_o}), 128'({2'b11, w, 2'b00}));
      chk({tag, " bus64"}, 128'({if64.wb_sel_o, if64.wb_adr_o, if64.wb_dat_o}),
          128'({b, a >> 3, wd}));
   endtask

   // Expected view outside BUS: rv selects RESP (1) or IDLE (0)
   task automatic chk_resp(input string tag, input logic rv, input logic e,
                           input logic [63:0] rd);
      chk({tag, " ctl32"}, 128'({if32.wb_cyc_o, if32.wb_stb_o, if32.obi_gnt_o,
                                 if32.obi_rvalid_o, if32.obi_err_o}), 128'({3'b001, rv, e}));
      chk({tag, " rdata32"}, 128'(if32.obi_rdata_o), 128'(rd[31:0]));
      chk({tag, " ctl64"}, 128'({if64.wb_cyc_o, if64.wb_stb_o, if64.obi_gnt_o,
                                 if64.obi_rvalid_o, if64.obi_err_o}), 128'({3'b001, rv, e}));
      chk({tag, " rdata64"}, 128'(if64.obi_rdata_o), 128'(rd));
   endtask

   // One complete transfer starting from IDLE at a falling edge
   task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                       input logic [7:0] b, input logic [63:0] wd, input int waits,
                       input int kind, input logic [63:0] d);
      int          ncyc;
      logic        e;
      logic [63:0] rd;
      req = 1'b1; addr = a; we = w; be = b; wdata = wd;
      @(posedge clk); @(negedge clk);
      req  = 1'b0;
      ncyc = (kind == 3) ? TO : waits + 1;
      for (int c = 1; c <= ncyc; c++) begin
         chk_bus(tag, a, w, b, wd);
         if (c == ncyc && kind != 3) begin
            ack = (kind != 1); err = (kind != 0); dat_i = d;
         end else begin
            dat_i = {$urandom, $urandom};
         end
         @(posedge clk); @(negedge clk);
         ack = 1'b0; err = 1'b0;
      end
      predict(w, kind, d, e, rd);
      chk_resp({tag, " resp"}, 1'b1, e, rd);
      // stray response after the cycle closed must be ignored
      ack = 1'b1; err = (kind == 2); dat_i = ~d;
      @(posedge clk); @(negedge clk);
      ack = 1'b0; err = 1'b0;
      chk_resp({tag, " idle"}, 1'b0, e, rd);
   endtask

   initial begin
      logic [31:0] ba [4];
      logic [7:0]  bb [4];
      logic [63:0] bd [4];
      req = 1'b0; we = 1'b0; ack = 1'b0; err = 1'b0;
      addr = '0; be = '0; wdata = '0; dat_i = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_resp("reset", 1'b0, 1'b0, 64'd0);
      chk("reset wb32", 128'({if32.wb_we_o, if32.wb_sel_o, if32.wb_adr_o, if32.wb_dat_o}), '0);
      chk("reset wb64", 128'({if64.wb_we_o, if64.wb_sel_o, if64.wb_adr_o, if64.wb_dat_o}), '0);
      rst_n = 1'b1;
      @(negedge clk);

      xfer("t1 write", 32'h0300_0010, 1'b1, 8'hFF, 64'hCAFEF00D_DEADBEEF, 0, 0, 64'h0);
      xfer("t2 read", 32'h0300_0010, 1'b0, 8'hFF, 64'h0, 3, 0, 64'h0BADC0DE_12345678);
      xfer("t3 ackerr", 32'h0300_0014, 1'b0, 8'h0F, 64'h0, 1, 2, 64'h5555_AAAA_1111_2222);
      xfer("t4 timeout", 32'h0300_0018, 1'b0, 8'hF0, 64'h0, 0, 3, 64'h7777_8888_9999_AAAA);

      for (int i = 0; i < 24; i++) begin
         int k;
         k = int'($urandom_range(0, 9));
         k = (k <= 5) ? 0 : (k <= 7) ? 1 : (k == 8) ? 2 : 3;
         xfer("rand", $urandom, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
              int'($urandom_range(0, 4)), k, {$urandom, $urandom});
      end

      // Back-to-back zero-wait writes with req held: next request granted in RESP
      for (int i = 0; i < 4; i++) begin
         ba[i] = $urandom; bb[i] = 8'($urandom); bd[i] = {$urandom, $urandom};
      end
      req = 1'b1; we = 1'b1; addr = ba[0]; be = bb[0]; wdata = bd[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk_bus("b2b", ba[i], 1'b1, bb[i], bd[i]);
         ack = 1'b1;
         if (i < 3) begin
            addr = ba[i+1]; be = bb[i+1]; wdata = bd[i+1];
         end else begin
            req = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         ack = 1'b0;
         chk_resp("b2b resp", 1'b1, 1'b0, 64'd0);
      end
      @(posedge clk); @(negedge clk);
      chk_resp("b2b idle", 1'b0, 1'b0, 64'd0);

      // Asynchronous reset in the middle of a WB cycle
      req = 1'b1; we = 1'b0; addr = 32'h1000_0020; be = 8'hFF; wdata = '0;
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      chk_bus("mid0", 32'h1000_0020, 1'b0, 8'hFF, 64'd0);
      @(posedge clk); @(negedge clk);
      chk_bus("mid1", 32'h1000_0020, 1'b0, 8'hFF, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_resp("mid async", 1'b0, 1'b0, 64'd0);
      ack = 1'b1; dat_i = {$urandom, $urandom};
      @(negedge clk);
      chk_resp("mid held", 1'b0, 1'b0, 64'd0);
      @(negedge clk);
      ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_resp("mid after", 1'b0, 1'b0, 64'd0);
      xfer("t6 read", 32'h0000_0040, 1'b0, 8'hFF, 64'h0, 1, 0, {$urandom, $urandom});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
